// File: rtl/reg_arb_pkg.sv
// reg_arb_pkg
//   Shared types for the register command arbiter.
//   - op_e    : command encoding carried on req_op (READ/LOAD/INC/DEC)
//   - state_e : arbiter FSM states (IDLE -> ISSUE -> RESP -> IDLE)
package reg_arb_pkg;

    typedef enum logic [1:0] {
        OP_READ = 2'b00,
        OP_LOAD = 2'b01,
        OP_INC  = 2'b10,
        OP_DEC  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ISSUE = 2'b01,
        ST_RESP  = 2'b10
    } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter
//   Combinational round-robin grant. Picks the first asserted request at or
//   after ptr, wrapping modulo NUM_REQ.
//   Ports:
//     req        in   NUM_REQ  request vector
//     ptr        in   ID_W     highest-priority index for this decision
//     grant      out  NUM_REQ  one-hot grant (all zero when no request)
//     grant_idx  out  ID_W     encoded index of the granted request
//     grant_any  out  1        at least one request present
module rr_arbiter #(
    parameter  int NUM_REQ = 4,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grant_idx,
    output logic               grant_any
);

    int idx;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        idx       = 0;
        // Scan NUM_REQ positions starting at ptr; the first hit wins.
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = int'(ptr) + i;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!grant_any && req[idx]) begin
                grant_any  = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = ID_W'(idx);
            end
        end
    end

endmodule

// File: rtl/reg_cmd_arbiter.sv
// reg_cmd_arbiter
//   Shares one external load/inc/dec register among NUM_REQ requesters.
//   One command is served at a time: IDLE (grant) -> ISSUE (strobe) -> RESP.
//   Ports:
//     clk, rst             clock (rising edge), async active-high reset
//     req_valid/ready      per-requester handshake; ready is a one-hot pulse
//     req_op, req_data     flattened per-requester op (2b) and LOAD data
//     rsp_valid/id/data    one-cycle response with post-operation value
//     rsp_err              saturation-blocked flag
//     reg_load/inc/dec     register strobes (mutually exclusive)
//     reg_in, reg_out      register load data / current register value
//     busy                 FSM not in IDLE
//   Build option: define REG_ARB_SAT_GUARD_EN to suppress INC at all-ones and
//   DEC at zero; the response then carries the unchanged value with rsp_err=1.
//
//   Handshake: a requester holds req_valid/op/data stable until it sees its
//   req_ready bit high in a cycle; the command is accepted at that clock edge.
//   req_ready is only ever high in IDLE, for the granted index alone. A request
//   dropped before it is granted is not served.
module reg_cmd_arbiter
    import reg_arb_pkg::*;
#(
    parameter  int DATA_SIZE = 11,
    parameter  int NUM_REQ   = 4,
    localparam int ID_W      = $clog2(NUM_REQ)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_REQ-1:0]           req_valid,
    output logic [NUM_REQ-1:0]           req_ready,
    input  logic [2*NUM_REQ-1:0]         req_op,
    input  logic [DATA_SIZE*NUM_REQ-1:0] req_data,
    output logic                         rsp_valid,
    output logic [ID_W-1:0]              rsp_id,
    output logic [DATA_SIZE-1:0]         rsp_data,
    output logic                         rsp_err,
    output logic                         reg_load,
    output logic                         reg_inc,
    output logic                         reg_dec,
    output logic [DATA_SIZE-1:0]         reg_in,
    input  logic [DATA_SIZE-1:0]         reg_out,
    output logic                         busy
);

    state_e               state_q, state_d;
    logic [ID_W-1:0]      ptr_q, ptr_d;
    logic [ID_W-1:0]      id_q, id_d;
    op_e                  op_q, op_d;
    logic [DATA_SIZE-1:0] data_q, data_d;
`ifdef REG_ARB_SAT_GUARD_EN
    logic                 err_q, err_d;
    logic                 blocked;
`endif

    logic [NUM_REQ-1:0]   grant;
    logic [ID_W-1:0]      grant_idx;
    logic                 grant_any;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr_arbiter (
        .req       (req_valid),
        .ptr       (ptr_q),
        .grant     (grant),
        .grant_idx (grant_idx),
        .grant_any (grant_any)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            id_q    <= '0;
            op_q    <= OP_READ;
            data_q  <= '0;
`ifdef REG_ARB_SAT_GUARD_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            id_q    <= id_d;
            op_q    <= op_d;
            data_q  <= data_d;
`ifdef REG_ARB_SAT_GUARD_EN
            err_q   <= err_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        id_d      = id_q;
        op_d      = op_q;
        data_d    = data_q;
        req_ready = '0;
        rsp_valid = 1'b0;
        rsp_id    = '0;
        rsp_data  = '0;
        rsp_err   = 1'b0;
        reg_load  = 1'b0;
        reg_inc   = 1'b0;
        reg_dec   = 1'b0;
        reg_in    = '0;
        busy      = (state_q != ST_IDLE);
`ifdef REG_ARB_SAT_GUARD_EN
        err_d     = err_q;
        blocked   = 1'b0;
`endif

        case (state_q)
            ST_IDLE: begin
                if (grant_any) begin
                    req_ready = grant;
                    id_d      = grant_idx;
                    op_d      = op_e'(req_op[grant_idx*2 +: 2]);
                    data_d    = req_data[grant_idx*DATA_SIZE +: DATA_SIZE];
                    // Next decision starts just past the winner.
                    ptr_d     = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + ID_W'(1);
                    state_d   = ST_ISSUE;
                end
            end

            ST_ISSUE: begin
                reg_in = data_q;
`ifdef REG_ARB_SAT_GUARD_EN
                blocked = ((op_q == OP_INC) && (&reg_out)) ||
                          ((op_q == OP_DEC) && (reg_out == '0));
                err_d   = blocked;
                reg_load = (op_q == OP_LOAD);
                reg_inc  = (op_q == OP_INC) && !blocked;
                reg_dec  = (op_q == OP_DEC) && !blocked;
`else
                reg_load = (op_q == OP_LOAD);
                reg_inc  = (op_q == OP_INC);
                reg_dec  = (op_q == OP_DEC);
`endif
                state_d = ST_RESP;
            end

            ST_RESP: begin
                // The register updated on the ISSUE edge, so reg_out is post-op.
                reg_in    = data_q;
                rsp_valid = 1'b1;
                rsp_id    = id_q;
                rsp_data  = reg_out;
`ifdef REG_ARB_SAT_GUARD_EN
                rsp_err   = err_q;
`endif
                state_d   = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_reg_cmd_arbiter.sv
module tb_reg_cmd_arbiter;
    import reg_arb_pkg::*;

    localparam int DW   = 11;
    localparam int NR   = 4;
    localparam int IDW  = 2;
`ifdef REG_ARB_SAT_GUARD_EN
    localparam bit SAT  = 1'b1;
`else
    localparam bit SAT  = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic [NR-1:0]   req_valid;
    logic [NR-1:0]   req_ready;
    logic [2*NR-1:0] req_op;
    logic [DW*NR-1:0] req_data;
    logic            rsp_valid;
    logic [IDW-1:0]  rsp_id;
    logic [DW-1:0]   rsp_data;
    logic            rsp_err;
    logic            reg_load, reg_inc, reg_dec;
    logic [DW-1:0]   reg_in;
    logic [DW-1:0]   reg_out;
    logic            busy;

    int n_checks = 0;
    int n_fail   = 0;
    logic [IDW+DW:0] exp_q[$];

    reg_cmd_arbiter #(.DATA_SIZE(DW), .NUM_REQ(NR)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_data  (req_data),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .reg_load  (reg_load),
        .reg_inc   (reg_inc),
        .reg_dec   (reg_dec),
        .reg_in    (reg_in),
        .reg_out   (reg_out),
        .busy      (busy)
    );

    // Clock
    always #5 clk = ~clk;

    // External shared register (not reset by rst).
    logic [DW-1:0] reg_val = '0;
    assign reg_out = reg_val;
    always @(posedge clk) begin
        if (reg_load)     reg_val <= reg_in;
        else if (reg_inc) reg_val <= reg_val + 1'b1;
        else if (reg_dec) reg_val <= reg_val - 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: pop and compare on every response strobe.
    always @(negedge clk) begin
        if (reg_load | reg_inc | reg_dec) begin
            check("strobe_onehot", 32'({reg_load, reg_inc, reg_dec}),
                  32'($onehot({reg_load, reg_inc, reg_dec}) ? {reg_load, reg_inc, reg_dec} : 3'b000));
        end
        if (rsp_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_rsp", 32'({rsp_id, rsp_data, rsp_err}), 32'hFFFF_FFFF);
            end else begin
                check("rsp_id_data_err", 32'({rsp_id, rsp_data, rsp_err}), 32'(exp_q.pop_front()));
            end
        end
    end

    task automatic expect_rsp(input int id, input logic [DW-1:0] d, input logic e);
        exp_q.push_back({IDW'(id), d, e});
    endtask

    // Driver: present a command, wait (bounded) for its ready pulse, then drop valid.
    // Entered just after a rising edge; returns just after the edge following acceptance.
    task automatic send(input int id, input op_e op, input logic [DW-1:0] d);
        bit got = 1'b0;
        req_valid[id]           = 1'b1;
        req_op[id*2 +: 2]       = op;
        req_data[id*DW +: DW]   = d;
        for (int c = 0; c < 20 && !got; c++) begin
            @(negedge clk);
            if (req_ready[id]) begin
                got = 1'b1;
                check("ready_onehot", 32'(req_ready), 32'(1 << id));
            end
            @(posedge clk); #1;
        end
        if (!got) check("ready_timeout", 0, 1);
        req_valid[id] = 1'b0;
    endtask

    task automatic wait_idle();
        bit idle = 1'b0;
        for (int c = 0; c < 20 && !idle; c++) begin
            @(negedge clk);
            if (!busy) idle = 1'b1;
        end
        if (!idle) check("idle_timeout", 0, 1);
        @(posedge clk); #1;
    endtask

    initial begin
        logic [NR-1:0] clr;
        int nxt;

        // Reset block
        rst = 1'b1; req_valid = '0; req_op = '0; req_data = '0;
        @(negedge clk);
        check("rst_outputs", 32'({req_ready, rsp_valid, rsp_id, rsp_data, rsp_err}), 0);
        check("rst_reg_strobes", 32'({reg_load, reg_inc, reg_dec, reg_in, busy}), 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // 1: reset in the middle of ISSUE of an INC
        send(0, OP_INC, '0);
        check("pre_rst_inc", 32'(reg_inc), 1);
        rst = 1'b1; #1;
        check("mid_rst_inc", 32'(reg_inc), 0);
        check("mid_rst_rsp", 32'(rsp_valid), 0);
        check("mid_rst_busy", 32'(busy), 0);
        check("mid_rst_ready", 32'(req_ready), 0);
        @(negedge clk); rst = 1'b0;
        repeat (3) @(posedge clk); #1;
        check("mid_rst_reg_unchanged", 32'(reg_out), 0);

        // 2: req0 LOAD 0x155, timing t / t+1 / t+2
        expect_rsp(0, 11'h155, 1'b0);
        send(0, OP_LOAD, 11'h155);
        @(negedge clk);
        check("load_strobe_t1", 32'({reg_load, reg_inc, reg_dec}), 32'b100);
        check("load_reg_in_t1", 32'(reg_in), 32'h155);
        @(negedge clk);
        check("rsp_valid_t2", 32'(rsp_valid), 1);
        check("load_strobe_t2", 32'(reg_load), 0);
        wait_idle();

        // Bring pointer back to 0 and register to 0 via req3.
        expect_rsp(3, 11'h000, 1'b0);
        send(3, OP_LOAD, 11'h000);
        wait_idle();

        // 3: all four INC at once -> grant order 0,1,2,3
        for (int i = 0; i < NR; i++) begin
            req_op[i*2 +: 2] = OP_INC;
            expect_rsp(i, DW'(i + 1), 1'b0);
        end
        req_valid = '1;
        nxt = 0;
        for (int c = 0; c < 40 && nxt < NR; c++) begin
            @(negedge clk);
            clr = req_ready;
            if (req_ready != '0) begin
                check("rr_order", 32'(req_ready), 32'(1 << nxt));
                nxt++;
            end
            @(posedge clk); #1;
            req_valid = req_valid & ~clr;
        end
        check("rr_all_granted", 32'(nxt), NR);
        req_valid = '0;
        wait_idle();

        // 4: READ from req2 with register at 0x07F
        expect_rsp(0, 11'h07F, 1'b0);
        send(0, OP_LOAD, 11'h07F);
        wait_idle();
        expect_rsp(2, 11'h07F, 1'b0);
        send(2, OP_READ, 11'h3AA);
        @(negedge clk);
        check("read_no_strobe", 32'({reg_load, reg_inc, reg_dec}), 0);
        wait_idle();

        // 5: INC at all-ones
        expect_rsp(3, 11'h7FF, 1'b0);
        send(3, OP_LOAD, 11'h7FF);
        wait_idle();
        expect_rsp(1, SAT ? 11'h7FF : 11'h000, SAT);
        send(1, OP_INC, 11'h000);
        @(negedge clk);
        check("inc_top_strobe", 32'(reg_inc), 32'(!SAT));
        wait_idle();

        // 6: DEC at zero
        expect_rsp(0, 11'h000, 1'b0);
        send(0, OP_LOAD, 11'h000);
        wait_idle();
        expect_rsp(1, SAT ? 11'h000 : 11'h7FF, SAT);
        send(1, OP_DEC, 11'h000);
        @(negedge clk);
        check("dec_zero_strobe", 32'(reg_dec), 32'(!SAT));
        wait_idle();

        repeat (2) @(posedge clk);
        check("queue_drained", 32'(exp_q.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
